// File: rtl/fq_pkg.sv
// Shared widths, entry type and PC helper for the instruction fetch queue.
package fq_pkg;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 11'd1;
    endfunction

endpackage

// File: rtl/fq_ring.sv
// DEPTH-entry ring buffer holding fetched words with their PC.
// Flush drops all entries at once; push and pop may coincide at any occupancy.
module fq_ring
    import fq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    output fq_entry_t        head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer and occupancy bookkeeping; flush takes priority over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only visible through count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: credit-limited sequential imem reads, fetch FIFO, redirect flush.
// Optional FQ_BYPASS_EN forwards a returning word straight to ID when the FIFO is empty.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = 11'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   im_addr,
    output logic                im_oen,
    input  logic [INSTR_W-1:0]  im_rdata,
    output logic [INSTR_W-1:0]  ir_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                ir_valid,
    input  logic                ir_ready,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 3;

    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [MEM_LAT-1:0] trk_valid_r;
    logic [ADDR_W-1:0]  trk_pc_r [MEM_LAT];

    logic [SUM_W-1:0]   inflight_s;
    logic [SUM_W-1:0]   credit_sum_s;
    logic               issue_s;
    logic               ret_valid_s;
    logic               byp_s;
    logic               push_s;
    logic               pop_s;
    logic               ring_empty_s;
    logic [CNT_W-1:0]   ring_count_s;
    fq_entry_t          ring_head_s;
    fq_entry_t          push_data_s;

    // Number of fetches still owed by imem, including the one returning now.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (trk_valid_r[i]) begin
                inflight_s = inflight_s + SUM_W'(1'b1);
            end else begin
                inflight_s = inflight_s;
            end
        end
    end

    assign credit_sum_s = inflight_s + SUM_W'(ring_count_s);
    assign issue_s      = rst_n & ~redirect & (credit_sum_s < SUM_W'(DEPTH));
    assign ret_valid_s  = trk_valid_r[MEM_LAT-1];

`ifdef FQ_BYPASS_EN
    assign byp_s = rst_n & ~redirect & ring_empty_s & ret_valid_s;
`else
    assign byp_s = 1'b0;
`endif

    // A bypassed word that ID takes immediately never enters storage.
    assign push_s      = rst_n & ~redirect & ret_valid_s & ~(byp_s & ir_ready);
    assign pop_s       = rst_n & ~redirect & ir_ready & ~ring_empty_s;
    assign push_data_s = '{pc: trk_pc_r[MEM_LAT-1], instr: im_rdata};

    // Fetch PC and tracker valid bits; redirect restarts the stream and drops in-flight data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r  <= RESET_PC;
            trk_valid_r <= '0;
        end else if (redirect) begin
            fetch_pc_r  <= redirect_pc;
            trk_valid_r <= '0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= pc_inc(fetch_pc_r);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            trk_valid_r[0] <= issue_s;
            for (int i = 1; i < MEM_LAT; i++) begin
                trk_valid_r[i] <= trk_valid_r[i-1];
            end
        end
    end

    // Tracker PC shift; qualified by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        trk_pc_r[0] <= fetch_pc_r;
        for (int i = 1; i < MEM_LAT; i++) begin
            trk_pc_r[i] <= trk_pc_r[i-1];
        end
    end

    fq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (ring_head_s),
        .empty     (ring_empty_s),
        .count     (ring_count_s)
    );

    // imem request and ID-facing output mux; stored head wins over a bypassed word.
    always_comb begin
        im_addr  = fetch_pc_r;
        im_oen   = ~issue_s;
        ir_valid = 1'b0;
        ir_out   = NOP_INSTR;
        pc_out   = '0;
        if (!rst_n) begin
            im_addr = RESET_PC;
        end else if (!ring_empty_s) begin
            ir_valid = 1'b1;
            ir_out   = ring_head_s.instr;
            pc_out   = ring_head_s.pc;
        end else if (byp_s) begin
            ir_valid = 1'b1;
            ir_out   = im_rdata;
            pc_out   = trk_pc_r[MEM_LAT-1];
        end else begin
            ir_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed literal checks.
module tb_fetch_queue;
    import fq_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          MEM_LAT  = 3;
    localparam logic [10:0] RESET_PC = 11'h000;
`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT_EXP = BYP ? MEM_LAT : MEM_LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] im_addr;
    logic        im_oen;
    logic [31:0] im_rdata;
    logic [31:0] ir_out;
    logic [10:0] pc_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [10:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .MEM_LAT  (MEM_LAT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im_addr     (im_addr),
        .im_oen      (im_oen),
        .im_rdata    (im_rdata),
        .ir_out      (ir_out),
        .pc_out      (pc_out),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct { logic [10:0] pc; int due; } pend_t;
    typedef struct { logic [10:0] pc; logic [31:0] instr; } word_t;

    pend_t       pend_q[$];
    word_t       fifo_q[$];
    logic [10:0] m_pc;
    int          cyc;
    bit          model_ok;
    int          n_checks;
    int          n_fail;

    logic        obs_oen, obs_valid;
    logic [10:0] obs_addr, obs_pc;
    logic [31:0] obs_ir;

    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return 32'h0000_0100 + {21'h0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic r, input logic rdy, input logic rd, input logic [10:0] rpc);
        logic        ret, issue, byp, valid;
        int          cnt;
        logic [31:0] rdata, e_ir;
        logic [10:0] e_pc, e_addr;
        rst_n       = r;
        ir_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        ret   = (pend_q.size() > 0) && (pend_q[0].due == cyc);
        rdata = ret ? mem_word(pend_q[0].pc) : $urandom;
        im_rdata = rdata;
        #1;
        obs_oen   = im_oen;
        obs_addr  = im_addr;
        obs_valid = ir_valid;
        obs_ir    = ir_out;
        obs_pc    = pc_out;
        if (!r) model_ok = 1'b1;
        cnt    = fifo_q.size();
        issue  = r && !rd && ((cnt + pend_q.size()) < DEPTH);
        byp    = BYP && r && !rd && (cnt == 0) && ret;
        valid  = r && ((cnt > 0) || byp);
        e_addr = r ? m_pc : RESET_PC;
        e_ir   = NOP_INSTR;
        e_pc   = 11'h000;
        if (valid && cnt > 0) begin
            e_ir = fifo_q[0].instr;
            e_pc = fifo_q[0].pc;
        end else if (valid) begin
            e_ir = rdata;
            e_pc = pend_q[0].pc;
        end
        if (model_ok) begin
            chk("im_oen", {31'h0, obs_oen}, {31'h0, !issue});
            chk("im_addr", {21'h0, obs_addr}, {21'h0, e_addr});
            chk("ir_valid", {31'h0, obs_valid}, {31'h0, valid});
            chk("ir_out", obs_ir, e_ir);
            chk("pc_out", {21'h0, obs_pc}, {21'h0, e_pc});
        end
        if (!r) begin
            m_pc = RESET_PC;
            fifo_q.delete();
            pend_q.delete();
        end else if (rd) begin
            m_pc = rpc;
            fifo_q.delete();
            pend_q.delete();
        end else begin
            if (rdy && valid && cnt > 0) void'(fifo_q.pop_front());
            if (ret) begin
                if (!(byp && rdy)) fifo_q.push_back('{pc: pend_q[0].pc, instr: rdata});
                void'(pend_q.pop_front());
            end
            if (issue) begin
                pend_q.push_back('{pc: m_pc, due: cyc + MEM_LAT});
                m_pc = m_pc + 11'd1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int          first, n, nreq;
        bit          found;
        logic        r, rdy, rd;
        logic [10:0] rpc;
        logic [10:0] exp_e [3];
        exp_e = '{11'h7FE, 11'h7FF, 11'h000};
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        model_ok = 1'b0;
        m_pc     = RESET_PC;
        rst_n = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 11'h000; im_rdata = 32'h0;
        @(negedge clk);

        // A: free run after reset, sequential PCs and data
        cycle(1'b0, 1'b1, 1'b0, 11'h000);
        cycle(1'b0, 1'b1, 1'b0, 11'h000);
        chk("A_reset_valid", {31'h0, obs_valid}, 32'h0);
        chk("A_reset_oen", {31'h0, obs_oen}, 32'h1);
        first = -1; n = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 11'h000);
            if (obs_valid) begin
                if (first < 0) first = i;
                chk("A_pc_seq", {21'h0, obs_pc}, 32'(n));
                chk("A_ir_seq", obs_ir, 32'h0000_0100 + 32'(n));
                n++;
            end
        end
        chk("A_first_valid_cycle", 32'(first), 32'(LAT_EXP));

        // B: stalled consumer, exactly DEPTH requests then in-order release
        cycle(1'b0, 1'b0, 1'b0, 11'h000);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 11'h000);
            if (!obs_oen) begin
                chk("B_req_addr", {21'h0, obs_addr}, 32'(nreq));
                nreq++;
            end
        end
        chk("B_req_count", 32'(nreq), 32'd4);
        chk("B_head_pc", {21'h0, obs_pc}, 32'h0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 11'h000);
            if (obs_valid && n < 8) begin
                chk("B_release_pc", {21'h0, obs_pc}, 32'(n));
                n++;
            end
        end
        chk("B_release_count", 32'(n), 32'd8);

        // C: redirect with three fetches in flight
        cycle(1'b0, 1'b1, 1'b0, 11'h000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 11'h000);
        cycle(1'b1, 1'b1, 1'b1, 11'h040);
        chk("C_oen_in_redirect", {31'h0, obs_oen}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 11'h000);
            if (obs_valid && !found) begin
                found = 1'b1;
                chk("C_first_pc", {21'h0, obs_pc}, 32'h040);
                chk("C_first_ir", obs_ir, 32'h0000_0140);
            end
        end
        chk("C_found", {31'h0, found}, 32'h1);

        // D: redirect while full and consumer ready
        cycle(1'b0, 1'b0, 1'b0, 11'h000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 11'h000);
        chk("D_full_valid", {31'h0, obs_valid}, 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 11'h040);
        cycle(1'b1, 1'b1, 1'b0, 11'h000);
        chk("D_empty_after", {31'h0, obs_valid}, 32'h0);
        chk("D_oen_restart", {31'h0, obs_oen}, 32'h0);
        chk("D_addr_restart", {21'h0, obs_addr}, 32'h040);

        // E: PC wrap through 0x7FF
        cycle(1'b1, 1'b1, 1'b1, 11'h7FE);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 11'h000);
            if (obs_valid && n < 3) begin
                chk("E_wrap_pc", {21'h0, obs_pc}, {21'h0, exp_e[n]});
                chk("E_wrap_ir", obs_ir, mem_word(exp_e[n]));
                n++;
            end
        end
        chk("E_wrap_count", 32'(n), 32'd3);

        // F: one-cycle reset mid-stream
        cycle(1'b0, 1'b1, 1'b0, 11'h000);
        chk("F_rst_oen", {31'h0, obs_oen}, 32'h1);
        chk("F_rst_addr", {21'h0, obs_addr}, {21'h0, RESET_PC});
        chk("F_rst_valid", {31'h0, obs_valid}, 32'h0);
        chk("F_rst_ir", obs_ir, 32'h0);
        chk("F_rst_pc", {21'h0, obs_pc}, 32'h0);
        first = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 11'h000);
            if (obs_valid && first < 0) begin
                first = i;
                chk("F_first_pc", {21'h0, obs_pc}, {21'h0, RESET_PC});
            end
        end
        chk("F_first_valid_cycle", 32'(first), 32'(LAT_EXP));

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(99) != 0);
            rd  = ($urandom_range(15) == 0);
            rdy = ((i / 400) % 2 == 0) ? ($urandom_range(9) < 8) : ($urandom_range(9) < 3);
            rpc = ($urandom_range(3) == 0) ? (11'h7FC + 11'($urandom_range(3)))
                                           : 11'($urandom_range(2047));
            cycle(r, rdy, rd, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
